dff_share_arbiter: RTL and testbench
====================================

// Module: dff_share_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for a shared W-bit D-register bank (q/qbar pair).
//  N requesters compete for write access to the bank; each grant loads the owner's data.
//  An optional lock lets one requester keep the register for a bounded burst.
//  Sits between requester logic and the shared dff bank; q/qbar feed downstream consumers.
// PARAMETERS
//  N        4   number of requesters (>=2)
//  W        8   register data width
//  MAX_HOLD 4   max consecutive grant cycles per locked burst (>=1)
// PORTS
//  clk    in   1              rising-edge clock
//  rst_n  in   1              synchronous, active-low reset
//  req    in   N              request per requester; held until granted
//  lock   in   N              requester wants burst ownership (sampled only while granted)
//  din    in   N*W            data per requester; requester i occupies din[i*W +: W]
//  gnt    out  N              registered one-hot grant (all zero when idle)
//  owner  out  $clog2(N)      index of current grantee (valid while busy)
//  busy   out  1              high whenever gnt != 0
//  q      out  W              shared register contents
//  qbar   out  W              always ~q, same cycle
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, gnt=0, busy=0, owner=0, q=0, qbar={W{1}},
//   hold_cnt=0, rr_ptr=N-1 (requester 0 wins first). Reset overrides every other input,
//   including mid-burst; outputs take reset values at that edge.
//  Arbitration (combinational): winner = first i with req[i]=1, scanning rr_ptr+1, rr_ptr+2, ...
//   modulo N (wrap N-1 -> 0).
//  States: IDLE, GRANT, LOCKED.
//   IDLE:   no req -> stay. Any req -> next edge: gnt=onehot(winner), owner=winner, GRANT.
//   GRANT:  on each edge where gnt[k]=1: q<=din[k]; rr_ptr<=k.
//           If lock[k]&&req[k]&&MAX_HOLD>1 -> LOCKED, hold_cnt=1, gnt unchanged.
//           Else winner excluding... none: recompute winner (rr_ptr now k); any req -> GRANT
//           to new winner (may be k again only if it is the sole requester); no req -> IDLE, gnt=0.
//   LOCKED: q<=din[k] every cycle; hold_cnt++.
//           Leave when req[k]=0 or lock[k]=0 or hold_cnt==MAX_HOLD-1 (burst = MAX_HOLD cycles);
//           exit transition identical to GRANT's non-lock branch.
//  Latency: req rises in cycle t (IDLE) -> gnt in t+1 -> q holds din in t+2.
//  Single-requester case: sole requester re-granted every cycle back-to-back (no bubble).
//  Contention: no requester waits more than (N-1)*MAX_HOLD grant cycles.
//  gnt is never multi-hot; busy == |gnt; qbar == ~q at all times.
//  req dropped before grant: allowed, simply not selected. lock ignored for non-owners.
//  Simultaneous req+lock on a fresh winner: first cycle counts as burst cycle 1.
// TESTING
//  1 rst_n=0 2 cycles, req=4'b1111 -> gnt=0, busy=0, q=8'h00, qbar=8'hFF throughout.
//  2 req=0010, din1=8'hA5, one cycle -> gnt=0010 next cycle, then q=A5/qbar=5A, IDLE, gnt=0.
//  3 req=1111 held, lock=0 -> gnt sequence 0001,0010,0100,1000,0001; q tracks din of each.
//  4 req=0101, lock=0100, MAX_HOLD=4 -> after req0 grant, gnt=0100 for exactly 4 cycles, then 0001.
//  5 locked burst on req2, drop req2 at burst cycle 2 -> gnt leaves 2 on next edge, goes to req0.
//  6 rst_n=0 during LOCKED burst -> next edge gnt=0, q=0, qbar=FF; after release req0 served first.

Source files
------------

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter for a shared W-bit register bank (q/qbar pair).
// The grantee's data loads on every granted edge; lock extends ownership for up to MAX_HOLD cycles.
module dff_share_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         lock,
  input  logic [N*W-1:0]       din,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic [W-1:0]         q,
  output logic [W-1:0]         qbar
);
  localparam int LW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GRANT  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [LW-1:0] owner_q, owner_d;
  logic [LW-1:0] rr_ptr_q, rr_ptr_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [W-1:0]  q_q, q_d;

  logic [LW-1:0] arb_ptr;
  logic [LW-1:0] win_idx;
  logic          win_found;
  logic [W-1:0]  din_own;
  logic          own_req, own_lock;

  // While busy the owner is the pointer this edge will commit, so scan from it directly.
  always_comb begin
    int idx;
    arb_ptr   = busy ? owner_q : rr_ptr_q;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(arb_ptr) + i) % N;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = LW'(idx);
      end
    end
  end

  assign din_own  = din[int'(owner_q)*W +: W];
  assign own_req  = req[owner_q];
  assign own_lock = lock[owner_q];

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    q_d        = q_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_GRANT;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_idx;
          owner_d = win_idx;
        end
      end
      S_GRANT, S_LOCKED: begin
        q_d        = din_own;
        rr_ptr_d   = owner_q;
        hold_cnt_d = hold_cnt_q + HW'(1);
        if (state_q == S_GRANT && MAX_HOLD > 1 && own_lock && own_req) begin
          state_d    = S_LOCKED;
          hold_cnt_d = HW'(1);
        end else if (state_q == S_LOCKED && own_req && own_lock &&
                     hold_cnt_q != HW'(MAX_HOLD - 1)) begin
          state_d = S_LOCKED;
        end else if (win_found) begin
          state_d    = S_GRANT;
          gnt_d      = {{(N-1){1'b0}}, 1'b1} << win_idx;
          owner_d    = win_idx;
          hold_cnt_d = '0;
        end else begin
          state_d    = S_IDLE;
          gnt_d      = '0;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        gnt_d      = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= LW'(N - 1);
      hold_cnt_q <= '0;
      q_q        <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      q_q        <= q_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = |gnt_q;
  assign q     = q_q;
  assign qbar  = ~q_q;
endmodule

// File: tb/tb_dff_share_arbiter.sv
// Directed bench for dff_share_arbiter (N=4, W=8, MAX_HOLD=4) with hand-computed expectations.
module tb_dff_share_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, lock;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt;
  logic [1:0]     owner;
  logic           busy;
  logic [W-1:0]   q, qbar;

  int n_cmp = 0;
  int n_err = 0;

  dff_share_arbiter #(.N(N), .W(W), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .din(din),
    .gnt(gnt), .owner(owner), .busy(busy), .q(q), .qbar(qbar)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle past it before checking.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    lock  = 4'b0000;
    din   = {8'h3C, 8'hC3, 8'hA5, 8'h11};

    // reset dominates pending requests
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_qbar", 32'(qbar), 32'hFF);
    end

    // single one-cycle request
    rst_n = 1'b1;
    req   = 4'b0010;
    tick();
    chk("one_gnt", 32'(gnt), 32'h2);
    chk("one_busy", 32'(busy), 32'h1);
    chk("one_owner", 32'(owner), 32'h1);
    req = 4'b0000;
    tick();
    chk("one_q", 32'(q), 32'hA5);
    chk("one_qbar", 32'(qbar), 32'h5A);
    chk("one_idle", 32'(gnt), 32'h0);
    chk("one_busy0", 32'(busy), 32'h0);

    // full contention, no lock: plain rotation
    do_reset();
    req = 4'b1111;
    tick(); chk("rr_g0", 32'(gnt), 32'h1);
    tick(); chk("rr_g1", 32'(gnt), 32'h2); chk("rr_q0", 32'(q), 32'h11);
    tick(); chk("rr_g2", 32'(gnt), 32'h4); chk("rr_q1", 32'(q), 32'hA5);
    tick(); chk("rr_g3", 32'(gnt), 32'h8); chk("rr_q2", 32'(q), 32'hC3);
    tick(); chk("rr_g4", 32'(gnt), 32'h1); chk("rr_q3", 32'(q), 32'h3C);
    chk("rr_owner", 32'(owner), 32'h0);

    // locked burst of exactly MAX_HOLD cycles
    do_reset();
    req  = 4'b0101;
    lock = 4'b0100;
    tick(); chk("lk_g0", 32'(gnt), 32'h1);
    tick(); chk("lk_b1", 32'(gnt), 32'h4); chk("lk_q0", 32'(q), 32'h11);
    tick(); chk("lk_b2", 32'(gnt), 32'h4); chk("lk_q2", 32'(q), 32'hC3);
    din[2*W +: W] = 8'h77;
    tick(); chk("lk_b3", 32'(gnt), 32'h4); chk("lk_qtrack", 32'(q), 32'h77);
    din[2*W +: W] = 8'hC3;
    tick(); chk("lk_b4", 32'(gnt), 32'h4);
    tick(); chk("lk_exit", 32'(gnt), 32'h1); chk("lk_exit_q", 32'(q), 32'hC3);

    // burst cut short by dropping req2 in burst cycle 2
    tick(); chk("dr_b1", 32'(gnt), 32'h4);
    tick(); chk("dr_b2", 32'(gnt), 32'h4);
    req = 4'b0001;
    tick(); chk("dr_exit", 32'(gnt), 32'h1); chk("dr_owner", 32'(owner), 32'h0);

    // reset in the middle of a locked burst
    req = 4'b0101;
    tick(); chk("rl_b1", 32'(gnt), 32'h4);
    tick(); chk("rl_b2", 32'(gnt), 32'h4);
    rst_n = 1'b0;
    tick();
    chk("rl_gnt", 32'(gnt), 32'h0);
    chk("rl_q", 32'(q), 32'h00);
    chk("rl_qbar", 32'(qbar), 32'hFF);
    chk("rl_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick(); chk("rl_first", 32'(gnt), 32'h1);

    // sole requester re-granted back to back
    req  = 4'b1000;
    lock = 4'b0000;
    tick(); chk("so_g0", 32'(gnt), 32'h8); chk("so_q0", 32'(q), 32'h11);
    tick(); chk("so_g1", 32'(gnt), 32'h8); chk("so_q1", 32'(q), 32'h3C);
    tick(); chk("so_g2", 32'(gnt), 32'h8); chk("so_own", 32'(owner), 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
